// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: multiplexed common-anode seven-segment scanner with blanking, LZ suppression and fault blink
module sseg_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int DWELL_BITS = 16,
    parameter int BLINK_BITS = 25,
    parameter int LZ_BLANK   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digit_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  fault,
    input  logic                  clear_fault,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  fault_active
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]   dps_q, dps_d;
    logic [DWELL_BITS-1:0] presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BLINK_BITS-1:0] blink_q, blink_d;
    logic                fault_q, fault_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [3:0]          code;
    logic [6:0]          glyph;
    logic [DIGITS-1:0]   lz_sup;
    logic                zero_run;
    logic                dark;
    logic [DIGITS-1:0]   an_sel;

    assign seg          = seg_q;
    assign dp           = dp_q;
    assign an           = an_q;
    assign fault_active = fault_q;
    assign code         = shadow_q[4*int'(idx_q) +: 4];
    assign an_sel       = ~(DIGITS'(1) << idx_q);

    // State register: everything, outputs included, clears on reset
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q <= '0;
            dps_q    <= '0;
            presc_q  <= '0;
            idx_q    <= '0;
            blink_q  <= '0;
            fault_q  <= 1'b0;
            seg_q    <= 7'h7f;
            dp_q     <= 1'b1;
            an_q     <= '1;
        end else begin
            shadow_q <= shadow_d;
            dps_q    <= dps_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            blink_q  <= blink_d;
            fault_q  <= fault_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
        end
    end

    // Shadow load, dwell prescaler, digit index, sticky fault and blink phase
    always_comb begin
        shadow_d = load ? digit_data : shadow_q;
        dps_d    = load ? dp_in : dps_q;
        presc_d  = presc_q + 1'b1;
        idx_d    = &presc_q ? (idx_q == LAST ? '0 : idx_q + 1'b1) : idx_q;
        fault_d  = fault | (fault_q & ~clear_fault);
        blink_d  = (fault_d & ~fault_q) ? '0 : blink_q + 1'b1;
    end

    // A digit is a leading zero when it and every digit above it are 0 with no dp
    always_comb begin
        zero_run = 1'b1;
        lz_sup   = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run  = zero_run & (shadow_q[4*i +: 4] == 4'd0) & ~dps_q[i];
            lz_sup[i] = zero_run;
        end
    end

    // Glyph decode, segments active-low {g,f,e,d,c,b,a}
    always_comb begin
        case (code)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            4'd10:   glyph = 7'b0000011;
            4'd11:   glyph = 7'b0001110;
            4'd12:   glyph = 7'b1000111;
            4'd13:   glyph = 7'b0101111;
            4'd14:   glyph = 7'b1111111;
            default: glyph = 7'b0111111;
        endcase
    end

    // Next output word: fault overrides masks and LZ, blink gates only the anodes
    always_comb begin
        dark = blank_mask[idx_q] | ((LZ_BLANK != 0) & lz_sup[idx_q]);
        seg_d = fault_q ? GLYPH_F : dark ? 7'h7f : glyph;
        dp_d  = fault_q ? 1'b1 : dark ? 1'b1 : ~dps_q[idx_q];
        an_d  = fault_q ? (blink_q[BLINK_BITS-1] ? '1 : an_sel) : dark ? '1 : an_sel;
    end
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: directed plus random stimulus against a time-based display model
module tb_sseg_scan_driver;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digit_data = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic [3:0]  blank_mask = '0;
    logic        fault = 1'b0;
    logic        clear_fault = 1'b0;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fa0, fa1;
    logic [3:0]  an0, an1;

    int passed = 0;
    int total = 0;

    int          t;
    logic [3:0]  sh [4];
    logic [3:0]  dps;
    logic        flt;
    int          fc;
    logic [3:0]  e_an0, e_an1;
    logic [6:0]  e_seg0, e_seg1;
    logic        e_dp0, e_dp1, e_fa;

    logic [6:0] glyph_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000, 7'b0000011, 7'b0001110,
                                   7'b1000111, 7'b0101111, 7'b1111111, 7'b0111111};
    logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    sseg_scan_driver #(.DIGITS(4), .DWELL_BITS(2), .BLINK_BITS(4), .LZ_BLANK(0)) u_dut (
        .clock(clock), .reset(reset), .digit_data(digit_data), .dp_in(dp_in), .load(load),
        .blank_mask(blank_mask), .fault(fault), .clear_fault(clear_fault),
        .seg(seg0), .dp(dp0), .an(an0), .fault_active(fa0));

    sseg_scan_driver #(.DIGITS(4), .DWELL_BITS(2), .BLINK_BITS(4), .LZ_BLANK(1)) u_lz (
        .clock(clock), .reset(reset), .digit_data(digit_data), .dp_in(dp_in), .load(load),
        .blank_mask(blank_mask), .fault(fault), .clear_fault(clear_fault),
        .seg(seg1), .dp(dp1), .an(an1), .fault_active(fa1));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // What the panel should show given elapsed scan time and current contents
    task automatic model_out(input bit lz, output logic [3:0] a, output logic [6:0] s, output logic d);
        int pos;
        bit dark, allz;
        pos = (t / 4) % 4;
        if (flt) begin
            s = 7'b0001110;
            d = 1'b1;
            a = ((fc / 8) % 2 == 1) ? 4'hF : ~(4'b0001 << pos);
        end else begin
            dark = blank_mask[pos];
            if (lz && pos > 0) begin
                allz = 1'b1;
                for (int j = pos; j < 4; j++) if (sh[j] != 4'd0 || dps[j]) allz = 1'b0;
                if (allz) dark = 1'b1;
            end
            a = dark ? 4'hF : ~(4'b0001 << pos);
            s = dark ? 7'h7f : glyph_tbl[sh[pos]];
            d = dark ? 1'b1 : ~dps[pos];
        end
    endtask

    task automatic tick();
        logic nf;
        if (reset) begin
            e_an0 = 4'hF; e_an1 = 4'hF; e_seg0 = 7'h7f; e_seg1 = 7'h7f;
            e_dp0 = 1'b1; e_dp1 = 1'b1; e_fa = 1'b0;
            t = 0; dps = '0; flt = 1'b0; fc = 0;
            for (int j = 0; j < 4; j++) sh[j] = '0;
        end else begin
            model_out(1'b0, e_an0, e_seg0, e_dp0);
            model_out(1'b1, e_an1, e_seg1, e_dp1);
            nf = fault | (flt & ~clear_fault);
            fc = (nf && !flt) ? 0 : fc + 1;
            flt = nf;
            e_fa = flt;
            if (load) begin
                for (int j = 0; j < 4; j++) sh[j] = digit_data[4*j +: 4];
                dps = dp_in;
            end
            t++;
        end
        @(negedge clock);
        chk("an", an0, e_an0);
        chk("seg", seg0, e_seg0);
        chk("dp", dp0, e_dp0);
        chk("an_lz", an1, e_an1);
        chk("seg_lz", seg1, e_seg1);
        chk("dp_lz", dp1, e_dp1);
        chk("fault_active", fa0, e_fa);
        chk("fault_active_lz", fa1, e_fa);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_an", an0, 4'hF);
        chk("reset_fa", fa0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("scan_an", an0, an_seq[(i / 4) % 4]);
            chk("scan_seg0", seg0, 7'b1000000);
        end
        digit_data = 16'hB57F; dp_in = 4'b0010; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (an0 == 4'b1101) begin
                chk("slot1_seg", seg0, 7'b1111000);
                chk("slot1_dp", dp0, 1'b0);
            end
            if (an0 == 4'b1110) chk("slot0_seg", seg0, 7'b0111111);
            if (an0 == 4'b0111) chk("slot3_seg", seg0, 7'b0001110);
        end
        digit_data = 16'h0030; dp_in = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (16) tick();
        digit_data = 16'h0000; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (16) tick();
        digit_data = 16'hB57F; dp_in = 4'b0010; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 16 && !((t / 4) % 4 == 2 && t % 4 == 1); i++) tick();
        blank_mask = 4'b0100;
        tick();
        chk("blank_an", an0, 4'hF);
        repeat (8) tick();
        blank_mask = 4'b0000;
        fault = 1'b1;
        tick();
        fault = 1'b0;
        chk("fault_set", fa0, 1'b1);
        repeat (40) tick();
        fault = 1'b1; clear_fault = 1'b1;
        tick();
        fault = 1'b0; clear_fault = 1'b0;
        chk("set_wins", fa0, 1'b1);
        repeat (5) tick();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("cleared", fa0, 1'b0);
        repeat (8) tick();
        fault = 1'b1;
        tick();
        fault = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        chk("reset_mid_fa", fa0, 1'b0);
        chk("reset_mid_an", an0, 4'hF);
        reset = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 1000; i++) begin
            load = ($urandom_range(0, 7) == 0);
            digit_data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) digit_data[15:8] = '0;
            dp_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 15) == 0) blank_mask = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            fault = ($urandom_range(0, 63) == 0);
            clear_fault = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
